// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA raster timing driven by a pixel-enable strobe.
// Produces registered hsync/vsync/video_on, pixel coordinates and
// line/frame start pulses, all describing the same pixel.
// Optional macro VGA_SYNC_FRAME_CNT_EN adds an 8-bit frame counter output.
module vga_sync_gen #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_ACTIVE = 0,
    parameter int CNT_W       = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
`ifdef VGA_SYNC_FRAME_CNT_EN
    output logic [7:0]       frame_cnt,
`endif
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic             SYNC_ON  = (SYNC_ACTIVE != 0);
    localparam logic             SYNC_OFF = (SYNC_ACTIVE == 0);

    logic [CNT_W-1:0] r_x, r_y;
    logic             r_hsync, r_vsync, r_video_on, r_line_start, r_frame_start;

    logic [CNT_W-1:0] w_x_nxt, w_y_nxt;
    logic             w_x_wrap, w_hs_act, w_vs_act, w_vis, w_x_zero, w_xy_zero;

    // Next coordinate and the decode of that coordinate, so the registered
    // outputs always match the registered (x,y) with zero added latency.
    always_comb begin
        w_x_wrap  = (r_x == H_LAST);
        w_x_nxt   = w_x_wrap ? '0 : r_x + CNT_W'(1);
        w_y_nxt   = r_y;
        if (w_x_wrap)
            w_y_nxt = (r_y == V_LAST) ? '0 : r_y + CNT_W'(1);
        w_hs_act  = (w_x_nxt >= HS_FIRST) && (w_x_nxt <= HS_LAST);
        w_vs_act  = (w_y_nxt >= VS_FIRST) && (w_y_nxt <= VS_LAST);
        w_vis     = (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
        w_x_zero  = (w_x_nxt == '0);
        w_xy_zero = w_x_zero && (w_y_nxt == '0);
    end

    // Raster state; reset parks on the last pixel so the first strobe lands on (0,0).
    // Start pulses are cleared on non-strobe clocks so each is one clk wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= H_LAST;
            r_y           <= V_LAST;
            r_hsync       <= SYNC_OFF;
            r_vsync       <= SYNC_OFF;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hsync       <= w_hs_act ? SYNC_ON : SYNC_OFF;
            r_vsync       <= w_vs_act ? SYNC_ON : SYNC_OFF;
            r_video_on    <= w_vis;
            r_line_start  <= w_x_zero;
            r_frame_start <= w_xy_zero;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    // Frame tick counter; bumps on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_frame_cnt <= 8'd0;
        else if (pix_en && w_xy_zero)
            r_frame_cnt <= r_frame_cnt + 8'd1;
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen. Two instances share stimulus: the
// full 640x480 timing, and a tiny raster (10x7) so whole frames and frame
// counter wrap fit in a short run. Expected outputs come from a model that
// derives (x,y) arithmetically from the number of strobes since reset.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;

    logic       a_hs, a_vs, a_von, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_von, b_ls, b_fs;
    logic [3:0] b_x, b_y;
    logic [7:0] a_fc, b_fc;

    int checks = 0;
    int failures = 0;
    int n = 0;          // strobes seen since last reset
    pair_t q[$];

    always #5 clk = ~clk;

    vga_sync_gen u_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_cnt(a_fc),
`endif
        .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
        .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_sync_gen #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_ACTIVE(0), .CNT_W(4)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
`ifdef VGA_SYNC_FRAME_CNT_EN
        .frame_cnt(b_fc),
`endif
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
        .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs)
    );

`ifndef VGA_SYNC_FRAME_CNT_EN
    assign a_fc = 8'd0;
    assign b_fc = 8'd0;
`endif

    // Reference: pixel k = n-1 of an endless raster, x = k mod HT, y = (k div HT) mod VT.
    function automatic exp_t model(int cnt, bit pulse, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb);
        exp_t e;
        int ht, vt, k, px, py;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (cnt == 0) begin
            e.x = 10'(ht - 1); e.y = 10'(vt - 1);
            e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0;
            e.ls = 1'b0; e.fs = 1'b0; e.fc = 8'd0;
        end else begin
            k  = cnt - 1;
            px = k % ht;
            py = (k / ht) % vt;
            e.x   = 10'(px);
            e.y   = 10'(py);
            e.hs  = !(px >= hv + hf && px < hv + hf + hsw);
            e.vs  = !(py >= vv + vf && py < vv + vf + vsw);
            e.von = (px < hv) && (py < vv);
            e.ls  = pulse && (px == 0);
            e.fs  = pulse && (px == 0) && (py == 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
            e.fc  = 8'((k / (ht * vt) + 1) % 256);
`else
            e.fc  = 8'd0;
`endif
        end
        return e;
    endfunction

    function automatic exp_t act_a();
        exp_t e;
        e.x = a_x; e.y = a_y; e.hs = a_hs; e.vs = a_vs; e.von = a_von;
        e.ls = a_ls; e.fs = a_fs; e.fc = a_fc;
        return e;
    endfunction

    function automatic exp_t act_b();
        exp_t e;
        e.x = {6'd0, b_x}; e.y = {6'd0, b_y}; e.hs = b_hs; e.vs = b_vs; e.von = b_von;
        e.ls = b_ls; e.fs = b_fs; e.fc = b_fc;
        return e;
    endfunction

    task automatic chk(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d want x=%0d y=%0d hs=%b vs=%b von=%b ls=%b fs=%b fc=%0d",
                     name, $time, act.x, act.y, act.hs, act.vs, act.von, act.ls, act.fs, act.fc,
                     exp.x, exp.y, exp.hs, exp.vs, exp.von, exp.ls, exp.fs, exp.fc);
        end
    endtask

    // One clk of stimulus; the expectation for the coming edge goes to the scoreboard.
    task automatic step(input bit r, input bit pe);
        pair_t p;
        @(negedge clk);
        rst_n  = r;
        pix_en = pe;
        if (!r) n = 0;
        else if (pe) n++;
        p.a = model(n, r && pe, 640, 16, 96, 48, 480, 10, 2, 33);
        p.b = model(n, r && pe, 4, 1, 3, 2, 3, 1, 2, 1);
        q.push_back(p);
    endtask

    task automatic strobe4();
        step(1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0);
    endtask

    // Monitor: every edge the DUTs present a fresh output set; compare with the oldest expectation.
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                p = q.pop_front();
                chk("dut_full", act_a(), p.a);
                chk("dut_tiny", act_b(), p.b);
            end
        end
    end

    initial begin
        // Reset held, then released with no strobe yet: parked on last pixel.
        repeat (3) step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);

        // Divided strobe: a full line and then some.
        repeat (900) strobe4();

        // Freeze at x=300 for 50 clk; next strobe must give 301.
        while (((n - 1) % 800) != 300) strobe4();
        repeat (50) step(1'b1, 1'b0);
        strobe4();

        // Async reset between edges at x=700.
        while (((n - 1) % 800) != 700) strobe4();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_full", act_a(), model(0, 1'b0, 640, 16, 96, 48, 480, 10, 2, 33));
        chk("async_rst_tiny", act_b(), model(0, 1'b0, 4, 1, 3, 2, 3, 1, 2, 1));
        repeat (2) step(1'b0, 1'b0);
        repeat (2) step(1'b1, 1'b0);
        strobe4();

        // Continuous strobe: many tiny frames, including frame counter wrap.
        repeat (18500) step(1'b1, 1'b1);
        repeat (4) step(1'b1, 1'b0);

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
